inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 42 ++++
 rtl/inst_decode.sv | 48 ++++
 rtl/inst_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared word/register sizes, opcode and unit encodings, and the queue entry layout.
// Latency: none (definitions only). Backpressure: n/a.
`ifndef INST_QUEUE_DEFINES_SV
`define INST_QUEUE_DEFINES_SV
`define WORD_SIZE 32
`define REG_SIZE  6
`define UNIT_SIZE 3
`endif

package inst_queue_pkg;

    localparam logic [3:0] OP_LW   = 4'b1100;
    localparam logic [3:0] OP_SW   = 4'b1101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_MV   = 4'b1111;
    localparam logic [3:0] OP_HALT = 4'b0001;

    localparam logic [`UNIT_SIZE-1:0] UNIT_LW   = 3'b000;
    localparam logic [`UNIT_SIZE-1:0] UNIT_SW   = 3'b001;
    localparam logic [`UNIT_SIZE-1:0] UNIT_ADD  = 3'b010;
    localparam logic [`UNIT_SIZE-1:0] UNIT_MUL  = 3'b011;
    localparam logic [`UNIT_SIZE-1:0] UNIT_MV   = 3'b100;
    localparam logic [`UNIT_SIZE-1:0] UNIT_HALT = 3'b101;

    typedef struct packed {
        logic [`UNIT_SIZE-1:0] unit;
        logic [`REG_SIZE-1:0]  reg1;
        logic [`REG_SIZE-1:0]  reg2;
        logic [`REG_SIZE-1:0]  reg3;
        logic                  hasimm;
        logic [`WORD_SIZE-1:0] imm;
        logic [`WORD_SIZE-1:0] pc;
    } entry_t;

    // Memory and arithmetic units share the three-register / 15-bit immediate format.
    function automatic logic is_rrr_unit(input logic [`UNIT_SIZE-1:0] unit);
        return (unit == UNIT_LW) || (unit == UNIT_SW) ||
               (unit == UNIT_ADD) || (unit == UNIT_MUL);
    endfunction

endpackage

// File: rtl/inst_decode.sv
// Combinational instruction decoder feeding the queue write port.
// Latency: 0 cycles. Backpressure: none, pure function of inst/pc.
module inst_decode
    import inst_queue_pkg::*;
(
    input  logic [`WORD_SIZE-1:0] inst,
    input  logic [`WORD_SIZE-1:0] pc,
    output entry_t                entry,
    output logic                  store,
    output logic                  halt
);

    always_comb begin
        entry      = '0;
        store      = 1'b0;
        halt       = 1'b0;
        entry.pc   = pc;
        case (inst[31:28])
            OP_LW:   begin store = 1'b1; entry.unit = UNIT_LW;  end
            OP_SW:   begin store = 1'b1; entry.unit = UNIT_SW;  end
            OP_ADD:  begin store = 1'b1; entry.unit = UNIT_ADD; end
            OP_MUL:  begin store = 1'b1; entry.unit = UNIT_MUL; end
            OP_MV:   begin store = 1'b1; entry.unit = UNIT_MV;  end
            OP_HALT: begin store = 1'b1; entry.unit = UNIT_HALT; halt = 1'b1; end
            default: ;
        endcase

        if (store && is_rrr_unit(entry.unit)) begin
            entry.reg1 = inst[27:22];
            entry.reg2 = inst[21:16];
            if (inst[0]) begin
                entry.hasimm = 1'b1;
                entry.imm    = {{(`WORD_SIZE-15){inst[15]}}, inst[15:1]};
            end else begin
                entry.reg3   = inst[15:10];
            end
        end else if (store && entry.unit == UNIT_MV) begin
            entry.reg1 = inst[27:22];
            if (inst[0]) begin
                entry.hasimm = 1'b1;
                entry.imm    = {{(`WORD_SIZE-22){inst[21]}}, inst[21:0]};
            end else begin
                entry.reg2   = inst[21:16];
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Decoded-instruction FIFO between fetch and RS; INST_QUEUE_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle push-to-out (0 with bypass on an empty queue).
// Backpressure: in_ready low when full or halted; no pass-through when full.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [`WORD_SIZE-1:0]        in_inst,
    input  logic [`WORD_SIZE-1:0]        in_pc,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_unit,
    output logic [`REG_SIZE-1:0]         out_reg1,
    output logic [`REG_SIZE-1:0]         out_reg2,
    output logic [`REG_SIZE-1:0]         out_reg3,
    output logic                         out_hasimm,
    output logic signed [`WORD_SIZE-1:0] out_imm,
    output logic [`WORD_SIZE-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            halt_q;

    entry_t          dec_entry;
    logic            dec_store;
    logic            dec_halt;
    entry_t          head;

    logic            full;
    logic            empty;
    logic            push_fire;
    logic            byp_take;
    logic            do_push;
    logic            do_pop;

    inst_decode u_decode (
        .inst  (in_inst),
        .pc    (in_pc),
        .entry (dec_entry),
        .store (dec_store),
        .halt  (dec_halt)
    );

    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign in_ready  = !full && !halt_q && !rst;
    assign push_fire = in_valid && in_ready;

`ifdef INST_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass    = empty && push_fire && dec_store && !flush;
    assign byp_take  = bypass && out_ready;
    assign out_valid = !empty || bypass;
    assign head      = !empty ? mem[rd_ptr] : (bypass ? dec_entry : '0);
`else
    assign byp_take  = 1'b0;
    assign out_valid = !empty;
    assign head      = !empty ? mem[rd_ptr] : '0;
`endif

    // A bypassed entry never occupies a slot, so it must not also be written.
    assign do_push = push_fire && dec_store && !byp_take;
    assign do_pop  = out_ready && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= dec_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            halt_q <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push_fire && dec_halt) begin
                halt_q <= 1'b1;
            end
        end
    end

    assign out_unit   = head.unit;
    assign out_reg1   = head.reg1;
    assign out_reg2   = head.reg2;
    assign out_reg3   = head.reg3;
    assign out_hasimm = head.hasimm;
    assign out_imm    = head.imm;
    assign out_pc     = head.pc;
    assign count      = cnt;
    assign halted     = halt_q;

endmodule
